// File: rtl/lmul_sequencer_pkg.sv
// Shared definitions for the LMUL group sequencer: vlmul encodings, FSM state
// type and the encoding-to-group-size decode.
package lmul_sequencer_pkg;

    localparam logic [2:0] VLMUL_M1 = 3'b000;
    localparam logic [2:0] VLMUL_M2 = 3'b001;
    localparam logic [2:0] VLMUL_M4 = 3'b010;
    localparam logic [2:0] VLMUL_M8 = 3'b011;

    localparam int MAX_LMUL = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Reserved encodings (1xx) fall through to a group of one.
    function automatic logic [3:0] decode_lmul(input logic [2:0] enc);
        case (enc)
            VLMUL_M1: return 4'd1;
            VLMUL_M2: return 4'd2;
            VLMUL_M4: return 4'd4;
            VLMUL_M8: return 4'(MAX_LMUL);
            default:  return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/lmul_sequencer_decode.sv
// Combinational vlmul decode: group size N and the reserved-encoding flag.
module lmul_decode
    import lmul_sequencer_pkg::*;
(
    input  logic [2:0] lmul_enc,
    output logic [3:0] n,
    output logic       reserved
);

    assign n        = decode_lmul(lmul_enc);
    assign reserved = lmul_enc[2];

endmodule

// File: rtl/lmul_sequencer.sv
// Expands one register-group instruction into N single-register uops.
// Optional macro LMUL_ALIGN_CHECK_EN rejects bases that are not multiples of N.
module lmul_sequencer
    import lmul_sequencer_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NREGS)-1:0] raA,
    input  logic [$clog2(NREGS)-1:0] raB,
    input  logic [$clog2(NREGS)-1:0] rdest,
    input  logic [2:0]               lmul_enc,
    output logic                     uop_valid,
    input  logic                     uop_ready,
    output logic [$clog2(NREGS)-1:0] uop_raA,
    output logic [$clog2(NREGS)-1:0] uop_raB,
    output logic [$clog2(NREGS)-1:0] uop_rdest,
    output logic [2:0]               uop_idx,
    output logic                     uop_first,
    output logic                     uop_last,
    output logic                     lmul_stall,
    input  logic                     kill,
    output logic                     illegal
);

    localparam int IW = $clog2(NREGS);

    state_t          r_state;
    logic [IW-1:0]   r_ra_a;
    logic [IW-1:0]   r_ra_b;
    logic [IW-1:0]   r_rdest;
    logic [3:0]      r_n;
    logic [2:0]      r_count;
    logic            r_illegal;

    logic [3:0]      w_dec_n;
    logic            w_dec_reserved;
    logic            w_misaligned;
    logic            w_reject;
    logic            w_issue;
    logic            w_accept;
    logic            w_fire;
    logic            w_last;

    lmul_decode u_decode (
        .lmul_enc (lmul_enc),
        .n        (w_dec_n),
        .reserved (w_dec_reserved)
    );

`ifdef LMUL_ALIGN_CHECK_EN
    logic [IW-1:0] w_align_mask;
    assign w_align_mask = IW'(w_dec_n - 4'd1);
    assign w_misaligned = ((raA   & w_align_mask) != '0) ||
                          ((raB   & w_align_mask) != '0) ||
                          ((rdest & w_align_mask) != '0);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_reject = w_dec_reserved | w_misaligned;
    assign w_issue  = (r_state == ST_ISSUE);
    assign w_accept = !w_issue && in_valid && !kill && !w_reject;
    assign w_last   = w_issue && ({1'b0, r_count} == (r_n - 4'd1));
    assign w_fire   = w_issue && uop_ready;

    // NOTE: non-blocking only in here so every state register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ra_a    <= '0;
            r_ra_b    <= '0;
            r_rdest   <= '0;
            r_n       <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= !w_issue && in_valid && !kill && w_reject;
            if (kill) begin
                r_state <= ST_IDLE;
                r_count <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_ra_a  <= raA;
                            r_ra_b  <= raB;
                            r_rdest <= rdest;
                            r_n     <= w_dec_n;
                            r_count <= '0;
                            r_state <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (w_fire) begin
                            if (w_last) begin
                                r_state <= ST_IDLE;
                                r_count <= '0;
                            end else begin
                                r_count <= r_count + 3'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Register indices wrap naturally at the IW-bit adder width.
    assign in_ready   = !w_issue;
    assign uop_valid  = w_issue;
    assign uop_raA    = w_issue ? r_ra_a  + IW'(r_count) : '0;
    assign uop_raB    = w_issue ? r_ra_b  + IW'(r_count) : '0;
    assign uop_rdest  = w_issue ? r_rdest + IW'(r_count) : '0;
    assign uop_idx    = w_issue ? r_count : '0;
    assign uop_first  = w_issue && (r_count == 3'd0);
    assign uop_last   = w_last;
    assign lmul_stall = (w_issue && !(w_fire && w_last)) ||
                        (w_accept && (w_dec_n > 4'd1));
    assign illegal    = r_illegal;

endmodule

// File: doc/lmul_sequencer.md
LMUL_SEQUENCER -- requirements
Module: lmul_sequencer

Interface
REQ-001 SHALL have parameter NREGS, default 32, meaning the number of architectural vector registers; index width is clog2(NREGS) = 5.
REQ-002 SHALL have ports: clk input 1, the rising-edge clock; reset input 1, synchronous active-high.
REQ-003 SHALL have ports: in_valid input 1 (instruction offered); in_ready output 1 (instruction accepted when in_valid & in_ready).
REQ-004 SHALL have ports: raA, raB, rdest input 5 each (group base registers); lmul_enc input 3 (vlmul encoding: 000=1, 001=2, 010=4, 011=8).
REQ-005 SHALL have ports: uop_valid output 1; uop_ready input 1; uop_raA, uop_raB, uop_rdest output 5 each; uop_idx output 3 (member index); uop_first, uop_last output 1 each.
REQ-006 SHALL have ports: lmul_stall output 1 (front-end IF1/IF2 hold); kill input 1 (abort current group); illegal output 1 (one-cycle pulse on rejected instruction).

Function
REQ-007 SHALL implement FSM states IDLE and ISSUE, encoded 1 bit.
REQ-008 In IDLE: in_ready=1; on accept SHALL latch the bases and decoded group size N (1,2,4,8), clear count to 0, and go to ISSUE.
REQ-009 Reserved lmul_enc (1xx) SHALL decode to N=1 and assert illegal for one cycle; the instruction is dropped (no uops, stay IDLE).
REQ-010 In ISSUE: uop_valid=1; uop_r* = latched base + count, modulo 32; uop_idx=count; uop_first=(count==0); uop_last=(count==N-1).
REQ-011 Count SHALL advance only on uop_valid & uop_ready; outputs SHALL hold stable while uop_ready=0.
REQ-012 On a handshake with uop_last=1, the FSM SHALL return to IDLE; back-to-back acceptance is not allowed in that cycle (in_ready=0 throughout ISSUE).
REQ-013 First uop SHALL appear the cycle after accept (1-cycle latency); a group of N uops with uop_ready tied high SHALL occupy exactly N cycles.
REQ-014 lmul_stall SHALL be 1 in ISSUE unless the current cycle completes the uop_last handshake; it SHALL also be 1 in the accept cycle when N>1; otherwise 0.
REQ-015 kill SHALL force IDLE on the next edge, suppress any pending uop, and take priority over in_valid in IDLE (no accept that cycle).
REQ-016 In IDLE, uop_valid, uop_first, and uop_last SHALL be 0, and uop_r*/uop_idx SHALL be 0.

Reset
REQ-017 reset SHALL override kill and all handshakes, setting state=IDLE, count=0, latched fields=0, and illegal=0; outputs then follow REQ-016 and REQ-008 (in_ready=1, lmul_stall=0).
REQ-018 reset asserted mid-group SHALL discard the remaining uops with no further uop_valid.

Configuration
REQ-019 With macro LMUL_ALIGN_CHECK_EN defined, an instruction whose raA, raB, or rdest is not a multiple of N SHALL be rejected as in REQ-009 (illegal pulse, no uops).
REQ-020 Without LMUL_ALIGN_CHECK_EN, misaligned bases SHALL be issued unchanged, with register indices wrapping modulo 32 per REQ-010.

Structure
REQ-021 A shared package SHALL hold: the vlmul encoding constants, the FSM state typedef, the decode function mapping lmul_enc to N, and MAX_LMUL=8.
REQ-022 One sub-module, lmul_decode, SHALL be combinational and output N plus the reserved flag; everything else is in lmul_sequencer.

Verification
REQ-023 LMUL=4 (010), raA=8, raB=12, rdest=16, uop_ready=1 -> uops (8,12,16)..(11,15,19) on 4 consecutive cycles, first/last on idx 0/3, stall high 4 cycles.
REQ-024 LMUL=2, uop_ready low on the 2nd uop for 3 cycles -> uop fields frozen at idx 1 and lmul_stall held; completes after ready returns.
REQ-025 lmul_enc=101 -> illegal pulses 1 cycle, no uop_valid, in_ready stays 1.
REQ-026 LMUL=8, kill at idx 3 -> no uop with idx 4 appears, IDLE and in_ready=1 next cycle; reset at idx 2 behaves the same.
REQ-027 LMUL=4, rdest=30: with LMUL_ALIGN_CHECK_EN -> illegal; without -> rdest sequence 30, 31, 0, 1.
REQ-028 LMUL=1 back-to-back instructions -> one uop per 2 cycles, lmul_stall never asserted.
